// File: rtl/hrange_share_arbiter.sv
// hrange_share_arbiter
//   Lets NUM_REQ caller FSMs share one hrange-style generator. Each caller
//   pulses req_start with its (base, limit, step). The request is queued and,
//   in round-robin order, one caller at a time is granted the generator for
//   a whole run. The granted caller's arguments are issued with gen__start,
//   output beats pass straight through, and req_done pulses at run end.
// Ports
//   _clock, _reset        clock, synchronous active-high reset
//   req_start[i]          1-cycle pulse: capture requester i args, queue a run
//   req_base/limit/step   packed args, requester i at [i*WIDTH +: WIDTH]
//   req_ready[i]          consumer ready (only the granted bit matters)
//   req_valid[i], req_0   beat valid (granted bit only) and shared data
//   req_done[i]           registered 1-cycle pulse at end of requester i's run
//   grant, busy           one-hot owner (0 when idle); high in ISSUE and RUN
//   gen__reset            generator reset, follows _reset
//   gen__start            high for the single ISSUE cycle
//   gen_base/limit/step   captured args of the granted requester
//   gen__ready            consumer ready of the owner, during RUN only
//   gen__valid/done, gen_0  generator outputs
module hrange_share_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
) (
   input  logic                     _clock,
   input  logic                     _reset,
   input  logic [NUM_REQ-1:0]       req_start,
   input  logic [NUM_REQ*WIDTH-1:0] req_base,
   input  logic [NUM_REQ*WIDTH-1:0] req_limit,
   input  logic [NUM_REQ*WIDTH-1:0] req_step,
   input  logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       req_valid,
   output logic [WIDTH-1:0]         req_0,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     busy,
   output logic                     gen__reset,
   output logic                     gen__start,
   output logic [WIDTH-1:0]         gen_base,
   output logic [WIDTH-1:0]         gen_limit,
   output logic [WIDTH-1:0]         gen_step,
   output logic                     gen__ready,
   input  logic                     gen__valid,
   input  logic                     gen__done,
   input  logic [WIDTH-1:0]         gen_0
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = IW + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [NUM_REQ-1:0] pending_r;
   logic [WIDTH-1:0]   base_r  [NUM_REQ];
   logic [WIDTH-1:0]   limit_r [NUM_REQ];
   logic [WIDTH-1:0]   step_r  [NUM_REQ];
   logic [NUM_REQ-1:0] grant_r;
   logic [NUM_REQ-1:0] req_done_r;
   logic [IW-1:0]      gidx_r;
   logic [IW-1:0]      rr_ptr_r;
   logic               start_r;
   logic [WIDTH-1:0]   gen_base_r, gen_limit_r, gen_step_r;
   logic [IW-1:0]      pick_s;
   logic               pick_ok_s;
   logic [SW-1:0]      sum_s;
   logic [SW-1:0]      cand_s;
   logic               run_end_s;

   // Round-robin pick: first pending requester at or after rr_ptr, wrapping.
   // Scanning offsets from high to low lets the smallest offset win.
   always_comb begin
      pick_s    = '0;
      pick_ok_s = 1'b0;
      sum_s     = '0;
      cand_s    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum_s     = SW'(rr_ptr_r) + SW'(k);
         cand_s    = (sum_s >= SW'(NUM_REQ)) ? (sum_s - SW'(NUM_REQ)) : sum_s;
         pick_s    = pending_r[cand_s[IW-1:0]] ? cand_s[IW-1:0] : pick_s;
         pick_ok_s = pick_ok_s | pending_r[cand_s[IW-1:0]];
      end
   end

   // A run ends only once the generator is done with no beat left to hand over.
   assign run_end_s = (state_r == ST_RUN) && gen__done && !gen__valid;

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:  state_s = pick_ok_s ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_s = ST_RUN;
         ST_RUN:   state_s = run_end_s ? ST_IDLE : ST_RUN;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register, grant/owner, issued arguments and completion pulse.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state_r     <= ST_IDLE;
         grant_r     <= '0;
         gidx_r      <= '0;
         rr_ptr_r    <= '0;
         req_done_r  <= '0;
         start_r     <= 1'b0;
         gen_base_r  <= '0;
         gen_limit_r <= '0;
         gen_step_r  <= '0;
      end else begin
         state_r    <= state_s;
         req_done_r <= '0;
         start_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_ok_s) begin
                  grant_r     <= NUM_REQ'(1) << pick_s;
                  gidx_r      <= pick_s;
                  gen_base_r  <= base_r[pick_s];
                  gen_limit_r <= limit_r[pick_s];
                  gen_step_r  <= step_r[pick_s];
                  start_r     <= 1'b1;
               end
            end
            ST_ISSUE: begin
            end
            ST_RUN: begin
               if (run_end_s) begin
                  req_done_r <= grant_r;
                  grant_r    <= '0;
                  rr_ptr_r   <= (gidx_r == IW'(NUM_REQ - 1)) ? '0 : (gidx_r + IW'(1));
               end
            end
            default: begin
               grant_r <= '0;
            end
         endcase
      end
   end

   // Per-requester request queue. A new req_start beats the ISSUE clear, so a
   // requester re-arming while it is being issued keeps its new request.
   always_ff @(posedge _clock) begin
      if (_reset) begin
         pending_r <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            base_r[i]  <= '0;
            limit_r[i] <= '0;
            step_r[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start[i]) begin
               pending_r[i] <= 1'b1;
               base_r[i]    <= req_base[i*WIDTH +: WIDTH];
               limit_r[i]   <= req_limit[i*WIDTH +: WIDTH];
               step_r[i]    <= req_step[i*WIDTH +: WIDTH];
            end else if ((state_r == ST_ISSUE) && (gidx_r == IW'(i))) begin
               pending_r[i] <= 1'b0;
            end
         end
      end
   end

   // Beat pass-through: zero latency between generator and owning consumer.
   always_comb begin
      req_valid  = '0;
      req_0      = '0;
      gen__ready = 1'b0;
      if (state_r == ST_RUN) begin
         req_valid  = grant_r & {NUM_REQ{gen__valid}};
         req_0      = gen_0;
         gen__ready = |(grant_r & req_ready);
      end else begin
         req_valid  = '0;
         req_0      = '0;
         gen__ready = 1'b0;
      end
   end

   assign req_done   = req_done_r;
   assign grant      = grant_r;
   assign busy       = (state_r != ST_IDLE);
   assign gen__reset = _reset;
   assign gen__start = start_r;
   assign gen_base   = gen_base_r;
   assign gen_limit  = gen_limit_r;
   assign gen_step   = gen_step_r;

endmodule

// File: tb/tb_hrange_share_arbiter.sv
module tb_hrange_share_arbiter;

   localparam int N = 2;
   localparam int W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_start;
   logic [N*W-1:0]   req_base, req_limit, req_step;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     req_valid;
   logic [W-1:0]     req_0;
   logic [N-1:0]     req_done;
   logic [N-1:0]     grant;
   logic             busy;
   logic             gen__reset, gen__start, gen__ready;
   logic [W-1:0]     gen_base, gen_limit, gen_step;
   logic             gen__valid, gen__done;
   logic [W-1:0]     gen_0;

   hrange_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      ._clock(clk), ._reset(rst),
      .req_start(req_start), .req_base(req_base), .req_limit(req_limit),
      .req_step(req_step), .req_ready(req_ready), .req_valid(req_valid),
      .req_0(req_0), .req_done(req_done), .grant(grant), .busy(busy),
      .gen__reset(gen__reset), .gen__start(gen__start),
      .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
      .gen__ready(gen__ready), .gen__valid(gen__valid), .gen__done(gen__done),
      .gen_0(gen_0)
   );

   always #5 clk = ~clk;

   // Behavioural hrange generator: emits base, base+step, ... while < limit.
   logic signed [W-1:0] g_cur, g_lim, g_step;
   logic                g_act;
   always @(posedge clk) begin
      if (gen__reset) begin
         g_act <= 1'b0;
      end else if (gen__start) begin
         g_act  <= 1'b1;
         g_cur  <= gen_base;
         g_lim  <= gen_limit;
         g_step <= gen_step;
      end else if (g_act) begin
         if (g_cur < g_lim) begin
            if (gen__ready) g_cur <= g_cur + g_step;
         end else begin
            g_act <= 1'b0;
         end
      end
   end
   assign gen__valid = g_act && (g_cur < g_lim);
   assign gen__done  = g_act && !(g_cur < g_lim);
   assign gen_0      = g_cur;

   typedef struct { bit is_done; int idx; logic [W-1:0] val; } exp_t;
   typedef struct { int idx; logic [W-1:0] base; } gexp_t;
   exp_t  exp_q[$];
   gexp_t gq[$];

   int   n_vec = 0;
   int   n_err = 0;
   int   n_beats = 0;
   bit   end_req = 1'b0;
   logic rst_q;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic fail_note(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT output with nothing expected", nm);
   endtask

   always @(posedge clk) rst_q <= rst;

   // Monitor: compare every DUT-presented event against the scoreboard.
   always @(negedge clk) begin
      exp_t  e;
      gexp_t g;
      chk("gen_reset_follow", 64'(gen__reset), 64'(rst));
      if (rst_q) begin
         chk("rst_grant", 64'(grant), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_done", 64'(req_done), 64'd0);
         chk("rst_valid", 64'(req_valid), 64'd0);
         chk("rst_req0", 64'(req_0), 64'd0);
         chk("rst_start", 64'(gen__start), 64'd0);
         chk("rst_base", 64'(gen_base), 64'd0);
         chk("rst_limit", 64'(gen_limit), 64'd0);
         chk("rst_step", 64'(gen_step), 64'd0);
         chk("rst_gen_ready", 64'(gen__ready), 64'd0);
      end else begin
         chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
         chk("valid_in_grant", 64'(req_valid & ~grant), 64'd0);
         chk("gen_ready", 64'(gen__ready),
             64'(busy && !gen__start && (|(grant & req_ready))));
         if (gen__start) begin
            if (gq.size() == 0) fail_note("unexpected_start");
            else begin
               g = gq.pop_front();
               chk("grant_owner", 64'(grant), 64'(1) << g.idx);
               chk("issue_base", 64'(gen_base), 64'(g.base));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               n_beats++;
               if (exp_q.size() == 0) fail_note("unexpected_beat");
               else begin
                  e = exp_q.pop_front();
                  chk("beat_order", 64'(e.is_done), 64'd0);
                  chk("beat_owner", 64'(i), 64'(e.idx));
                  chk("beat_value", 64'(req_0), 64'(e.val));
               end
            end
            if (req_done[i]) begin
               if (exp_q.size() == 0) fail_note("unexpected_done");
               else begin
                  e = exp_q.pop_front();
                  chk("done_order", 64'(e.is_done), 64'd1);
                  chk("done_owner", 64'(i), 64'(e.idx));
               end
            end
         end
      end
      if (end_req) begin
         chk("beats_left", 64'(exp_q.size()), 64'd0);
         chk("issues_left", 64'(gq.size()), 64'd0);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   task automatic expect_run(input int i, input int b, input int l, input int s);
      gq.push_back('{i, W'(b)});
      for (int v = b; v < l; v += s) exp_q.push_back('{1'b0, i, W'(v)});
      exp_q.push_back('{1'b1, i, '0});
   endtask

   task automatic set_args(input int i, input int b, input int l, input int s);
      req_base[i*W +: W]  = W'(b);
      req_limit[i*W +: W] = W'(l);
      req_step[i*W +: W]  = W'(s);
   endtask

   task automatic pulse(input logic [N-1:0] m);
      req_start = m;
      @(posedge clk); #1;
      req_start = '0;
   endtask

   task automatic do_reset();
      req_start = '0;
      req_ready = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input bit toggle);
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (toggle) req_ready[0] = ~req_ready[0];
         if (exp_q.size() == 0 && gq.size() == 0 && !busy && req_done == '0) return;
      end
      $display("FAIL drain_timeout: %0d events still expected", exp_q.size() + gq.size());
      $fatal(1);
   endtask

   task automatic wait_done(input int i);
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (req_done[i]) return;
      end
      $display("FAIL wait_done_timeout: requester %0d never completed", i);
      $fatal(1);
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      req_start = '0;
      req_ready = '0;
      req_base = '0;
      req_limit = '0;
      req_step = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // T1 single run
      req_ready = 2'b01;
      expect_run(0, 0, 10, 2);
      set_args(0, 0, 10, 2);
      pulse(2'b01);
      drain(1'b0);

      // T2 contention: req0 first, then req1
      do_reset();
      req_ready = 2'b11;
      expect_run(0, 0, 4, 1);
      expect_run(1, 10, 12, 1);
      set_args(0, 0, 4, 1);
      set_args(1, 10, 12, 1);
      pulse(2'b11);
      drain(1'b0);

      // T3 backpressure
      do_reset();
      req_ready = 2'b01;
      expect_run(0, 0, 10, 2);
      set_args(0, 0, 10, 2);
      pulse(2'b01);
      drain(1'b1);

      // T4 fairness: re-arm in the cycle of own req_done
      do_reset();
      req_ready = 2'b11;
      expect_run(0, 0, 2, 1);
      expect_run(1, 20, 22, 1);
      expect_run(0, 4, 6, 1);
      expect_run(1, 30, 31, 1);
      set_args(0, 0, 2, 1);
      set_args(1, 20, 22, 1);
      pulse(2'b11);
      wait_done(0);
      set_args(0, 4, 6, 1);
      pulse(2'b01);
      wait_done(1);
      set_args(1, 30, 31, 1);
      pulse(2'b10);
      drain(1'b0);

      // T5 empty range
      do_reset();
      req_ready = 2'b01;
      expect_run(0, 5, 5, 1);
      set_args(0, 5, 5, 1);
      pulse(2'b01);
      drain(1'b0);

      // T6 reset after two beats, then a fresh run
      do_reset();
      req_ready = 2'b01;
      gq.push_back('{0, W'(0)});
      exp_q.push_back('{1'b0, 0, W'(0)});
      exp_q.push_back('{1'b0, 0, W'(2)});
      set_args(0, 0, 10, 2);
      n0 = n_beats;
      pulse(2'b01);
      for (int c = 0; c < 100 && n_beats < n0 + 2; c++) begin
         @(posedge clk); #1;
      end
      if (n_beats < n0 + 2) begin
         $display("FAIL t6_beats_timeout: got %0d beats, expected 2", n_beats - n0);
         $fatal(1);
      end
      do_reset();
      req_ready = 2'b01;
      expect_run(0, 0, 6, 2);
      set_args(0, 0, 6, 2);
      pulse(2'b01);
      drain(1'b0);

      repeat (2) @(posedge clk);
      #1 end_req = 1'b1;
      repeat (4) @(posedge clk);
      $display("FAIL summary_not_reached");
      $fatal(1);
   end

endmodule
